// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit seven-segment scanner with dead-time blanking, frame snapshot and leading-zero suppression
module display_scan_ctrl #(
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clkFPGA,
    input  logic        rst,
    input  logic        clk1KHz,
    input  logic        enable,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

    logic        r_clk_q;
    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_snap_bcd;
    logic [3:0]  r_snap_dp;
    logic [1:0]  r_idx;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        r_fd;

    logic        w_tick;
    logic [1:0]  w_nstate;
    logic [7:0]  w_ncnt;
    logic [15:0] w_nbcd;
    logic [3:0]  w_ndp;
    logic [1:0]  w_nidx;
    logic        w_nfd;
    logic [3:0]  w_nib;
    logic        w_sup;
    logic [6:0]  w_enc;

    assign w_tick     = clk1KHz & ~r_clk_q;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign digit_idx  = r_idx;
    assign frame_done = r_fd;

    // Edge detector history; resets high so a level already high at release is not an edge
    always_ff @(posedge clkFPGA) begin
        if (rst) r_clk_q <= 1'b1;
        else     r_clk_q <= clk1KHz;
    end

    // Next-state logic: enable drop beats everything, ticks in BLANK are ignored
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nbcd   = r_snap_bcd;
        w_ndp    = r_snap_dp;
        w_nidx   = r_idx;
        w_nfd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_tick) begin
                    w_nstate = BLANK;
                    w_ncnt   = BLANK_LOAD;
                    w_nbcd   = bcd;
                    w_ndp    = dp_in;
                    w_nidx   = 2'd0;
                end
            end
            BLANK: begin
                if (!enable) begin
                    w_nstate = IDLE;
                    w_ncnt   = 8'd0;
                    w_nidx   = 2'd0;
                end else if (r_cnt <= 8'd1) begin
                    w_nstate = SHOW;
                    w_ncnt   = 8'd0;
                end else begin
                    w_ncnt   = r_cnt - 8'd1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    w_nstate = IDLE;
                    w_nidx   = 2'd0;
                end else if (w_tick) begin
                    w_nstate = BLANK;
                    w_ncnt   = BLANK_LOAD;
                    w_nidx   = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_nbcd = bcd;
                        w_ndp  = dp_in;
                        w_nfd  = 1'b1;
                    end
                end
            end
            default: begin
                w_nstate = IDLE;
                w_ncnt   = 8'd0;
                w_nidx   = 2'd0;
            end
        endcase
    end

    assign w_nib = w_nbcd[w_nidx*4 +: 4];
    assign w_sup = blank_lz && (w_nidx == 2'd3 ? w_nbcd[15:12] == 4'd0 :
                                w_nidx == 2'd2 ? w_nbcd[15:8]  == 8'd0 :
                                w_nidx == 2'd1 ? w_nbcd[15:4]  == 12'd0 : 1'b0);

    // Active-low segment pattern for the nibble about to be shown; non-BCD nibbles show a dash
    always_comb begin
        w_enc = 7'h3F;
        case (w_nib)
            4'd0: w_enc = 7'h40;
            4'd1: w_enc = 7'h79;
            4'd2: w_enc = 7'h24;
            4'd3: w_enc = 7'h30;
            4'd4: w_enc = 7'h19;
            4'd5: w_enc = 7'h12;
            4'd6: w_enc = 7'h02;
            4'd7: w_enc = 7'h78;
            4'd8: w_enc = 7'h00;
            4'd9: w_enc = 7'h10;
            default: w_enc = 7'h3F;
        endcase
    end

    // State, snapshot and outputs registered from next-state values so pins line up with the state
    always_ff @(posedge clkFPGA) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_snap_bcd <= 16'd0;
            r_snap_dp  <= 4'd0;
            r_idx      <= 2'd0;
            r_fd       <= 1'b0;
            r_an       <= 4'hF;
            r_seg      <= 7'h7F;
            r_dp       <= 1'b1;
        end else begin
            r_state    <= w_nstate;
            r_cnt      <= w_ncnt;
            r_snap_bcd <= w_nbcd;
            r_snap_dp  <= w_ndp;
            r_idx      <= w_nidx;
            r_fd       <= w_nfd;
            r_an       <= (w_nstate == SHOW) ? ~(4'b0001 << w_nidx) : 4'hF;
            r_seg      <= (w_nstate == SHOW) ? (w_sup ? 7'h7F : w_enc) : 7'h7F;
            r_dp       <= (w_nstate == SHOW) ? ~w_ndp[w_nidx] : 1'b1;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed table-driven bench for the display scanner
module tb_display_scan_ctrl;
    localparam int BC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk1KHz = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bcd = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]      bcd;
        logic             lz;
        logic [3:0]       dpi;
        logic [3:0][6:0]  segs;
        logic [3:0]       dpx;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] an_exp[4];

    display_scan_ctrl #(.BLANK_CYCLES(BC)) dut (
        .clkFPGA(clk), .rst(rst), .clk1KHz(clk1KHz), .enable(enable),
        .bcd(bcd), .dp_in(dp_in), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        clk1KHz = 1'b1;
        step();
        clk1KHz = 1'b0;
    endtask

    task automatic blank_show(input int d, input logic [6:0] s, input logic dpx, input string tag);
        for (int i = 0; i < BC; i++) begin
            chk({tag, "_blank_an"}, 32'(an), 32'(4'hF));
            step();
        end
        chk({tag, "_an"}, 32'(an), 32'(an_exp[d]));
        chk({tag, "_idx"}, 32'(digit_idx), 32'(d[1:0]));
        chk({tag, "_seg"}, 32'(seg), 32'(s));
        chk({tag, "_dp"}, 32'(dp), 32'(dpx));
        chk({tag, "_fd"}, 32'(frame_done), 32'(1'b0));
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    initial begin
        an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        vecs[0] = '{16'h1234, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0050, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1110};
        vecs[2] = '{16'h0050, 1'b0, 4'b0100, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1011};
        vecs[3] = '{16'h00A0, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 1'b1, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
        vecs[5] = '{16'h5678, 1'b0, 4'b0000, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111};
        vecs[6] = '{16'h9FB0, 1'b1, 4'b0010, {7'h10, 7'h3F, 7'h3F, 7'h40}, 4'b1101};
        vecs[7] = '{16'h0C09, 1'b1, 4'b0000, {7'h7F, 7'h3F, 7'h40, 7'h10}, 4'b1111};

        step(); step(); step();
        chk("rst_an", 32'(an), 32'(4'hF));
        chk("rst_seg", 32'(seg), 32'(7'h7F));
        chk("rst_dp", 32'(dp), 32'(1'b1));
        chk("rst_idx", 32'(digit_idx), 32'(2'd0));
        chk("rst_fd", 32'(frame_done), 32'(1'b0));
        rst = 1'b0;
        step();
        enable = 1'b1;
        step();
        chk("idle_an", 32'(an), 32'(4'hF));

        for (int v = 0; v < 8; v++) begin
            restart();
            bcd = vecs[v].bcd;
            blank_lz = vecs[v].lz;
            dp_in = vecs[v].dpi;
            tick();
            for (int d = 0; d < 4; d++) begin
                if (d > 0) tick();
                blank_show(d, vecs[v].segs[d], vecs[v].dpx[d], $sformatf("v%0d_d%0d", v, d));
            end
            enable = 1'b0;
            step();
            chk($sformatf("v%0d_off_an", v), 32'(an), 32'(4'hF));
            chk($sformatf("v%0d_off_seg", v), 32'(seg), 32'(7'h7F));
            chk($sformatf("v%0d_off_idx", v), 32'(digit_idx), 32'(2'd0));
            chk($sformatf("v%0d_off_fd", v), 32'(frame_done), 32'(1'b0));
        end

        restart();
        bcd = 16'h1234;
        blank_lz = 1'b0;
        dp_in = 4'h0;
        tick();
        chk("f_t1_fd", 32'(frame_done), 32'(1'b0));
        blank_show(0, 7'h19, 1'b1, "f_d0");
        tick();
        chk("f_t2_fd", 32'(frame_done), 32'(1'b0));
        blank_show(1, 7'h30, 1'b1, "f_d1");
        bcd = 16'h9999;
        step(); step();
        chk("f_hold_seg", 32'(seg), 32'(7'h30));
        tick();
        chk("f_t3_fd", 32'(frame_done), 32'(1'b0));
        blank_show(2, 7'h24, 1'b1, "f_d2");
        tick();
        chk("f_t4_fd", 32'(frame_done), 32'(1'b0));
        blank_show(3, 7'h79, 1'b1, "f_d3");
        tick();
        chk("f_t5_fd", 32'(frame_done), 32'(1'b1));
        chk("f_t5_idx", 32'(digit_idx), 32'(2'd0));
        chk("f_t5_an", 32'(an), 32'(4'hF));
        blank_show(0, 7'h10, 1'b1, "f_new_d0");

        restart();
        bcd = 16'h1234;
        tick();
        step(); step(); step();
        tick();
        step(); step(); step();
        chk("ign_an", 32'(an), 32'(4'hF));
        chk("ign_idx", 32'(digit_idx), 32'(2'd0));
        step();
        chk("ign_show_an", 32'(an), 32'(4'b1110));
        chk("ign_show_seg", 32'(seg), 32'(7'h19));
        for (int d = 1; d < 4; d++) begin
            tick();
            blank_show(d, (d == 1) ? 7'h30 : (d == 2) ? 7'h24 : 7'h79, 1'b1, $sformatf("pri_d%0d", d));
        end
        enable = 1'b0;
        clk1KHz = 1'b1;
        step();
        clk1KHz = 1'b0;
        chk("pri_an", 32'(an), 32'(4'hF));
        chk("pri_idx", 32'(digit_idx), 32'(2'd0));
        chk("pri_fd", 32'(frame_done), 32'(1'b0));
        step();
        chk("pri_fd2", 32'(frame_done), 32'(1'b0));

        rst = 1'b1;
        clk1KHz = 1'b1;
        enable = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("hi_rel_an%0d", i), 32'(an), 32'(4'hF));
        end
        clk1KHz = 1'b0;
        step();
        tick();
        blank_show(0, 7'h19, 1'b1, "hi_d0");

        rst = 1'b1;
        step();
        chk("mid_rst_an", 32'(an), 32'(4'hF));
        chk("mid_rst_seg", 32'(seg), 32'(7'h7F));
        chk("mid_rst_idx", 32'(digit_idx), 32'(2'd0));
        rst = 1'b0;
        step(); step(); step();
        chk("mid_idle_an", 32'(an), 32'(4'hF));
        tick();
        blank_show(0, 7'h19, 1'b1, "mid_d0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
